ebus_arbiter: RTL and testbench

Arbitrates ownership of the shared 36-bit EBUS among the EBOX-internal drivers (EDP, IR, SCD, APR, CRA) and external EBUS masters (RH20, DTE20 front ends), replacing the free-running priority mux at the top level. It grants one requester at a time and registers that requester's data and device select onto EBUS/EBUS_DS. It then sequences a demand/transfer handshake with a bounded timeout and returns a completion or timeout indication to the owner. The block sits in the top level, between the ebox/device instances and the EBUS consumers.

---
 rtl/ebus_pkg.sv | 21 ++
 rtl/ebus_pick.sv | 33 +++
 rtl/ebus_arbiter.sv | 136 +++++++++++++
 tb/tb_ebus_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ebus_pkg.sv
// Shared types and constants for the EBUS arbiter.
// Round-robin arbitration is enabled by defining EBUS_RR_EN.
package ebus_pkg;

    localparam int EBUS_W    = 36;
    localparam int EBUS_DS_W = 8;

    localparam int EBUS_REQ_EDP = 0;
    localparam int EBUS_REQ_IR  = 1;
    localparam int EBUS_REQ_SCD = 2;
    localparam int EBUS_REQ_APR = 3;
    localparam int EBUS_REQ_CRA = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DEMAND,
        RELEASE
    } ebusState_t;

endpackage

// File: rtl/ebus_pick.sv
// Combinational winner select for the EBUS arbiter.
// Searches req starting at index start, wrapping at NREQ-1.
module ebus_pick
    import ebus_pkg::*;
#(
    parameter int NREQ = 5,
    parameter int IW   = 3
) (
    input  logic [0:NREQ-1] req,
    input  logic [IW-1:0]   start,
    output logic [0:NREQ-1] oneHot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // First requester at or after start wins; fixed priority when start is 0
    always_comb begin
        int j;
        j      = 0;
        oneHot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(start) + k) % NREQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = IW'(j);
                oneHot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ebus_arbiter.sv
// EBUS ownership arbiter with demand/transfer handshake and timeout.
// Define EBUS_RR_EN for round-robin; otherwise lowest index wins.
module ebus_arbiter
    import ebus_pkg::*;
#(
    parameter int NREQ    = 5,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [0:NREQ-1]          req,
    input  logic [0:NREQ*EBUS_W-1]   reqData,
    input  logic [0:NREQ*EBUS_DS_W-1] reqDS,
    input  logic                     ebusXfer,
    output logic [0:NREQ-1]          grant,
    output logic [0:EBUS_W-1]        EBUS,
    output logic [0:EBUS_DS_W-1]     EBUS_DS,
    output logic                     ebusDemand,
    output logic                     done,
    output logic                     timeout,
    output logic                     busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    ebusState_t      state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   start;
    logic [7:0]      cnt;
    logic [0:NREQ-1] pickHot;
    logic [IW-1:0]   pickIdx;
    logic            pickAny;
    logic            ownerReq;
    logic            cntHit;

    assign ownerReq = req[owner];
    assign cntHit   = (cnt == 8'(TIMEOUT));
    assign busy     = (state != IDLE);

    ebus_pick #(
        .NREQ(NREQ),
        .IW  (IW)
    ) uPick (
        .req   (req),
        .start (start),
        .oneHot(pickHot),
        .idx   (pickIdx),
        .any   (pickAny)
    );

`ifdef EBUS_RR_EN
    logic [IW-1:0] rrPtr;

    assign start = rrPtr;

    // Advance past the owner only when its transfer completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rrPtr <= '0;
        end else if (state == DEMAND && ownerReq && (ebusXfer || cntHit)) begin
            rrPtr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
        end
    end
`else
    assign start = '0;
`endif

    // Ownership FSM; every output except busy is registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            cnt        <= '0;
            grant      <= '0;
            EBUS       <= '0;
            EBUS_DS    <= '0;
            ebusDemand <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pickAny) begin
                        state   <= SETUP;
                        owner   <= pickIdx;
                        grant   <= pickHot;
                        EBUS    <= reqData[int'(pickIdx)*EBUS_W +: EBUS_W];
                        EBUS_DS <= reqDS[int'(pickIdx)*EBUS_DS_W +: EBUS_DS_W];
                    end
                end
                SETUP: begin
                    if (!ownerReq) begin
                        state   <= IDLE;
                        grant   <= '0;
                        EBUS    <= '0;
                        EBUS_DS <= '0;
                    end else begin
                        state      <= DEMAND;
                        cnt        <= '0;
                        ebusDemand <= 1'b1;
                    end
                end
                DEMAND: begin
                    if (!ownerReq) begin
                        state      <= IDLE;
                        grant      <= '0;
                        EBUS       <= '0;
                        EBUS_DS    <= '0;
                        ebusDemand <= 1'b0;
                    end else if (ebusXfer) begin
                        state      <= RELEASE;
                        done       <= 1'b1;
                        ebusDemand <= 1'b0;
                    end else if (cntHit) begin
                        state      <= RELEASE;
                        timeout    <= 1'b1;
                        ebusDemand <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RELEASE: begin
                    if (!ownerReq) begin
                        state   <= IDLE;
                        grant   <= '0;
                        EBUS    <= '0;
                        EBUS_DS <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ebus_arbiter.sv
// Self-checking bench for ebus_arbiter (works with or without EBUS_RR_EN).
// Directed steps plus random transactions against a transaction-level model.
module tb_ebus_arbiter;

    localparam int N  = 5;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic [0:N-1]    req;
    logic [0:N*36-1] reqData;
    logic [0:N*8-1]  reqDS;
    logic            ebusXfer;
    logic [0:N-1]    grant;
    logic [0:35]     EBUS;
    logic [0:7]      EBUS_DS;
    logic            ebusDemand;
    logic            done;
    logic            timeout;
    logic            busy;

    int tests    = 0;
    int failures = 0;
    int mPtr     = 0;

    ebus_arbiter #(
        .NREQ   (N),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .reqData   (reqData),
        .reqDS     (reqDS),
        .ebusXfer  (ebusXfer),
        .grant     (grant),
        .EBUS      (EBUS),
        .EBUS_DS   (EBUS_DS),
        .ebusDemand(ebusDemand),
        .done      (done),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [0:N-1] hot(input int w);
        logic [0:N-1] h;
        h = '0;
        if (w >= 0) h[w] = 1'b1;
        return h;
    endfunction

    function automatic logic [35:0] rnd36();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[35:0];
    endfunction

    // Arbitration rule: first set request at or after the start index
    function automatic int modelPick(input logic [0:N-1] r);
        int s;
        s = 0;
`ifdef EBUS_RR_EN
        s = mPtr;
`endif
        for (int k = 0; k < N; k++)
            if (r[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    task automatic scramble();
        for (int i = 0; i < N; i++) begin
            reqData[i*36 +: 36] = rnd36();
            reqDS[i*8 +: 8]     = 8'($urandom);
        end
    endtask

    task automatic checkIdle(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_ebus"}, EBUS, 0);
        chk({tag, "_ds"}, EBUS_DS, 0);
        chk({tag, "_demand"}, ebusDemand, 0);
        chk({tag, "_pulses"}, {done, timeout}, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Called at the negedge of an idle cycle; returns at the SETUP negedge
    task automatic grantPhase(input logic [0:N-1] r, output int w,
                              output logic [35:0] d, output logic [7:0] ds);
        req = r;
        w   = modelPick(r);
        d   = reqData[w*36 +: 36];
        ds  = reqDS[w*8 +: 8];
        step();
        chk("setup_grant", grant, hot(w));
        chk("setup_ebus", EBUS, d);
        chk("setup_ds", EBUS_DS, ds);
        chk("setup_demand", ebusDemand, 0);
        chk("setup_busy", busy, 1);
        scramble();
        ebusXfer = 1'($urandom);
    endtask

    // xferAt = demand cycle index at which ebusXfer is driven (-1: never)
    task automatic demandPhase(input int w, input logic [35:0] d,
                               input int xferAt);
        step();
        for (int k = 0; k <= TO; k++) begin
            chk("demand_high", ebusDemand, 1);
            chk("demand_quiet", {done, timeout}, 0);
            ebusXfer = (k == xferAt);
            step();
            if (k == xferAt) begin
                chk("done_pulse", done, 1);
                chk("done_no_timeout", timeout, 0);
                break;
            end else if (k == TO) begin
                chk("timeout_pulse", timeout, 1);
                chk("timeout_no_done", done, 0);
            end
        end
        ebusXfer = 1'b0;
        chk("release_demand", ebusDemand, 0);
        chk("release_busy", busy, 1);
        chk("release_grant", grant, hot(w));
        chk("release_ebus", EBUS, d);
        mPtr = (w + 1) % N;
    endtask

    task automatic releasePhase(input int w, input logic [35:0] d,
                                input logic [7:0] ds, input int hold);
        for (int h = 0; h < hold; h++) begin
            ebusXfer = 1'($urandom);
            step();
            chk("hold_grant", grant, hot(w));
            chk("hold_ebus", EBUS, d);
            chk("hold_ds", EBUS_DS, ds);
            chk("hold_pulses", {done, timeout, ebusDemand}, 0);
        end
        ebusXfer = 1'b0;
        req[w]   = 1'b0;
        step();
        checkIdle("idle");
    endtask

    task automatic txn(input logic [0:N-1] r, input int xferAt,
                       input int hold);
        int          w;
        logic [35:0] d;
        logic [7:0]  ds;
        grantPhase(r, w, d, ds);
        demandPhase(w, d, xferAt);
        releasePhase(w, d, ds, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          w2;
        logic [35:0] d;
        logic [7:0]  ds;
        logic [0:N-1] r;

        reset    = 1'b1;
        req      = '0;
        reqData  = '0;
        reqDS    = '0;
        ebusXfer = 1'b0;
        repeat (2) step();
        checkIdle("reset");
        reset = 1'b0;
        step();

        // Single request from IR with fixed data
        scramble();
        reqData[36 +: 36] = 36'o123456701234;
        reqDS[8 +: 8]     = 8'h3C;
        txn(5'b01000, 3, 1);

        // Timeout, then xfer exactly on the timeout cycle
        scramble();
        txn(5'b00100, -1, 0);
        scramble();
        txn(5'b00010, TO, 1);

        // Contention with every requester held
        for (int i = 0; i < 6; i++) begin
            scramble();
            txn(5'b11111, $urandom_range(0, 4), 0);
        end

        // Owner abandons the bus mid-demand; pending request follows
        scramble();
        grantPhase(5'b10100, w, d, ds);
        ebusXfer = 1'b0;
        step();
        step();
        chk("abort_demand", ebusDemand, 1);
        req[w] = 1'b0;
        step();
        checkIdle("abort");
        grantPhase(req, w2, d, ds);
        chk("abort_next_owner", grant, hot(modelPick(5'b10100 & ~hot(w))));
        demandPhase(w2, d, 2);
        releasePhase(w2, d, ds, 0);

        // Random transactions
        for (int i = 0; i < 25; i++) begin
            int xa;
            scramble();
            r = N'($urandom);
            if (r == '0) r = hot($urandom_range(0, N - 1));
            xa = $urandom_range(0, TO + 4);
            if (xa > TO) xa = -1;
            txn(r, xa, $urandom_range(0, 2));
        end

        // Asynchronous reset in DEMAND, then restart from pointer 0
        scramble();
        grantPhase(5'b00011, w, d, ds);
        ebusXfer = 1'b0;
        step();
        step();
        #2 reset = 1'b1;
        #1 checkIdle("async_reset");
        step();
        reset = 1'b0;
        mPtr  = 0;
        scramble();
        grantPhase(5'b01110, w, d, ds);
        chk("post_reset_owner", grant, 5'b01000);
        demandPhase(w, d, 0);
        releasePhase(w, d, ds, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
